// File: rtl/argmax_16_20.sv
// argmax_16_20: streaming argmax over N signed T-bit elements per vector.
// Tracks a running maximum and its index while a vector streams in, and
// presents the winning index/value once the last element has been accepted.
// The result is held until the downstream side takes it. No new element is
// accepted until then.

module argmax_16_20 #(
   parameter int T    = 20,
   parameter int N    = 16,
   parameter int LOGN = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic signed [T-1:0] data_in,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [LOGN-1:0]     data_out,
   output logic signed [T-1:0] max_out
);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   localparam logic [LOGN-1:0] CNT_ZERO = {LOGN{1'b0}};
   localparam logic [LOGN-1:0] CNT_ONE  = LOGN'(1);
   localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [LOGN-1:0]       count_r;
   logic signed [T-1:0]   best_r;
   logic [LOGN-1:0]       best_idx_r;
   logic                  m_valid_r;
   logic [LOGN-1:0]       data_out_r;
   logic signed [T-1:0]   max_out_r;

   logic                  s_ready_s;
   logic                  accept_s;
   logic                  result_taken_s;
   logic                  first_s;
   logic                  last_s;
   logic                  greater_s;
   logic signed [T-1:0]   best_nxt_s;
   logic [LOGN-1:0]       best_idx_nxt_s;

   // Strict signed greater-than; ties therefore keep the earlier index.
   function automatic logic is_greater(input logic signed [T-1:0] a,
                                       input logic signed [T-1:0] b);
      return (a > b);
   endfunction

   assign accept_s       = s_valid & s_ready_s;
   assign result_taken_s = m_valid_r & m_ready;
   assign first_s        = (count_r == CNT_ZERO);
   assign last_s         = (count_r == CNT_LAST);

   // Candidate running max including the element being accepted this cycle.
   always_comb begin
      greater_s      = is_greater(data_in, best_r);
      best_nxt_s     = best_r;
      best_idx_nxt_s = best_idx_r;
      if (first_s) begin
         // Element 0 always loads, never compared against a stale maximum.
         best_nxt_s     = data_in;
         best_idx_nxt_s = CNT_ZERO;
      end else if (greater_s) begin
         best_nxt_s     = data_in;
         best_idx_nxt_s = count_r;
      end else begin
         best_nxt_s     = best_r;
         best_idx_nxt_s = best_idx_r;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_COLLECT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: leave COLLECT on the last accept, leave HOLD on the result handshake.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_COLLECT: begin
            if (accept_s && last_s) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         ST_HOLD: begin
            if (result_taken_s) begin
               state_nxt_s = ST_COLLECT;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_COLLECT;
         end
      endcase
   end

   // Output decode: ready depends on state only, never on s_valid.
   always_comb begin
      s_ready_s = 1'b0;
      case (state_r)
         ST_COLLECT: s_ready_s = 1'b1;
         ST_HOLD:    s_ready_s = 1'b0;
         default:    s_ready_s = 1'b0;
      endcase
   end

   // Datapath: element counter, running max and the registered result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r    <= CNT_ZERO;
         best_r     <= {T{1'b0}};
         best_idx_r <= CNT_ZERO;
         m_valid_r  <= 1'b0;
         data_out_r <= CNT_ZERO;
         max_out_r  <= {T{1'b0}};
      end else begin
         case (state_r)
            ST_COLLECT: begin
               if (accept_s) begin
                  best_r     <= best_nxt_s;
                  best_idx_r <= best_idx_nxt_s;
                  if (last_s) begin
                     // Final element is folded in during the same cycle it is accepted.
                     count_r    <= CNT_ZERO;
                     m_valid_r  <= 1'b1;
                     data_out_r <= best_idx_nxt_s;
                     max_out_r  <= best_nxt_s;
                  end else begin
                     count_r <= count_r + CNT_ONE;
                  end
               end
            end
            ST_HOLD: begin
               // Result registers stay put; only the valid flag drops on handshake.
               if (result_taken_s) begin
                  m_valid_r <= 1'b0;
               end
            end
            default: begin
               count_r   <= CNT_ZERO;
               m_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready  = s_ready_s;
   assign m_valid  = m_valid_r;
   assign data_out = data_out_r;
   assign max_out  = max_out_r;

endmodule

// File: tb/tb_argmax_16_20.sv
// Directed testbench for argmax_16_20: one task per scenario, inline checks.

module tb_argmax_16_20;

   localparam int T    = 20;
   localparam int N    = 16;
   localparam int LOGN = 4;

   logic                clk;
   logic                reset;
   logic                s_valid;
   logic                s_ready;
   logic signed [T-1:0] data_in;
   logic                m_valid;
   logic                m_ready;
   logic [LOGN-1:0]     data_out;
   logic signed [T-1:0] max_out;

   int checks;
   int errors;

   logic signed [T-1:0] vec [N];

   argmax_16_20 #(.T(T), .N(N), .LOGN(LOGN)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .data_in  (data_in),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .data_out (data_out),
      .max_out  (max_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream vec[0..cnt-1]; optional idle gaps before elements. Returns at
   // posedge+1 after the last accept. m_valid must stay low until the final accept.
   task automatic send_vec(input int cnt, input bit gaps);
      for (int i = 0; i < cnt; i++) begin
         int waited;
         if (gaps) begin
            for (int g = 0; g < ((i * 7) % 3); g++) begin
               s_valid = 1'b0;
               tick();
            end
         end
         s_valid = 1'b1;
         data_in = vec[i];
         waited  = 0;
         while (!s_ready && waited < 50) begin
            tick();
            waited++;
         end
         checks++;
         if (waited >= 50) begin
            errors++;
            $display("FAIL send_timeout elem %0d: s_ready stuck at %0b, required 1", i, s_ready);
         end
         tick();
         if (i < N - 1) begin
            checks++;
            if (m_valid !== 1'b0) begin
               errors++;
               $display("FAIL early_valid elem %0d: m_valid=%0b, required 0", i, m_valid);
            end
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [LOGN-1:0] exp_idx,
                               input logic signed [T-1:0] exp_max);
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_valid: m_valid=%0b, required 1", name, m_valid);
      end
      checks++;
      if (data_out !== exp_idx) begin
         errors++;
         $display("FAIL %s_idx: data_out=%0d, required %0d", name, data_out, exp_idx);
      end
      checks++;
      if (max_out !== exp_max) begin
         errors++;
         $display("FAIL %s_max: max_out=%0d, required %0d", name, max_out, exp_max);
      end
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_hold_ready: s_ready=%0b, required 0", name, s_ready);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      data_in = '0;
      m_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b, required 0", m_valid); end
      checks++;
      if (data_out !== 4'd0) begin errors++; $display("FAIL reset_data_out: got %0d, required 0", data_out); end
      checks++;
      if (max_out !== 20'sd0) begin errors++; $display("FAIL reset_max_out: got %0d, required 0", max_out); end
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b, required 1", s_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_ascending();
      for (int i = 0; i < N; i++) vec[i] = T'(i);
      m_ready = 1'b0;
      send_vec(N, 1'b0);
      check_result("ascending", 4'd15, 20'sd15);
      m_ready = 1'b1;
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL asc_release_valid: got %0b, required 0", m_valid); end
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL asc_release_ready: got %0b, required 1", s_ready); end
      checks++;
      if (data_out !== 4'd15) begin errors++; $display("FAIL asc_keep_idx: got %0d, required 15", data_out); end
   endtask

   task automatic test_tie();
      for (int i = 0; i < N; i++) vec[i] = 20'sd2;
      vec[3] = 20'sd7;
      vec[9] = 20'sd7;
      m_ready = 1'b1;
      send_vec(N, 1'b0);
      check_result("tie", 4'd3, 20'sd7);
      tick();
   endtask

   task automatic test_negative();
      for (int i = 0; i < N; i++) vec[i] = T'(-20 - i);
      vec[0]  = -20'sd5;
      vec[1]  = -20'sd3;
      vec[2]  = -20'sd9;
      vec[12] = -20'sd1;
      m_ready = 1'b1;
      send_vec(N, 1'b0);
      check_result("negative", 4'd12, -20'sd1);
      tick();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) vec[i] = T'(i * 3);
      vec[5] = 20'sd100;
      m_ready = 1'b0;
      send_vec(N, 1'b0);
      check_result("bp", 4'd5, 20'sd100);
      // Offer a stray element while held: it must not be taken.
      s_valid = 1'b1;
      data_in = 20'sd999;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || data_out !== 4'd5 || max_out !== 20'sd100) begin
            errors++;
            $display("FAIL bp_stable cycle %0d: s_ready=%0b m_valid=%0b idx=%0d max=%0d, required 0 1 5 100",
                     c, s_ready, m_valid, data_out, max_out);
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b, required 0", m_valid); end
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b, required 1", s_ready); end
      checks++;
      if (max_out !== 20'sd100) begin errors++; $display("FAIL bp_keep_max: got %0d, required 100", max_out); end
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) vec[i] = T'(i * 10);
      vec[10] = 20'sd500;
      send_vec(N, 1'b1);
      check_result("b2b_first", 4'd10, 20'sd500);
      for (int i = 0; i < N; i++) vec[i] = T'(-100 + i);
      vec[0] = -20'sd10;
      vec[7] = 20'sd50;
      send_vec(N, 1'b1);
      check_result("b2b_second", 4'd7, 20'sd50);
      tick();
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) vec[i] = 20'sd1;
      vec[2] = 20'sd1000;
      send_vec(8, 1'b0);
      reset = 1'b1;
      #2;
      checks++;
      if (m_valid !== 1'b0 || data_out !== 4'd0 || max_out !== 20'sd0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_values: m_valid=%0b idx=%0d max=%0d s_ready=%0b, required 0 0 0 1",
                  m_valid, data_out, max_out, s_ready);
      end
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < N; i++) vec[i] = T'(i * 5);
      vec[0] = 20'sd300;
      send_vec(N, 1'b0);
      check_result("midreset", 4'd0, 20'sd300);
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_ascending();
      test_tie();
      test_negative();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
